// File: rtl/common_bus_select_if.sv
// common_bus_select_if: IR/timing inputs and registered bus-select outputs of the bus encoder.
// The r signal exists only when INTERRUPT_CYCLE_EN is defined.
interface common_bus_select_if;
    logic [15:0] in_ir;
    logic [2:0]  t;
`ifdef INTERRUPT_CYCLE_EN
    logic        r;
`endif
    logic [2:0]  s;
    logic        bus_err;

    modport master (
        output in_ir,
        output t,
`ifdef INTERRUPT_CYCLE_EN
        output r,
`endif
        input  s,
        input  bus_err
    );

    modport slave (
        input  in_ir,
        input  t,
`ifdef INTERRUPT_CYCLE_EN
        input  r,
`endif
        output s,
        output bus_err
    );
endinterface

// File: rtl/common_bus_select.sv
// common_bus_select: Mano common-bus source decoder and registered 3-bit select encoder.
// Optional INTERRUPT_CYCLE_EN adds the interrupt flip-flop r (TR to bus at R.T1).
module common_bus_select (
    input logic                clk,
    input logic                rst_n,
    common_bus_select_if.slave bus
);
    logic [7:0] d;
    logic [6:0] tt;
    logic       i_bit;
    logic       r_in;
    logic [7:1] x;
    logic [2:0] s_d, s_q;
    logic       err_d, err_q;

    always_comb begin
        d     = 8'b1 << bus.in_ir[14:12];
        i_bit = bus.in_ir[15];
        for (int k = 0; k < 7; k++) tt[k] = (bus.t == k[2:0]);
`ifdef INTERRUPT_CYCLE_EN
        r_in  = bus.r;
`else
        r_in  = 1'b0;
`endif
        x[1] = (d[4] & tt[4]) | (d[5] & tt[5]);
        x[2] = tt[0] | (d[5] & tt[4]);
        x[3] = d[6] & tt[6];
        x[4] = d[3] & tt[4];
        x[5] = ~r_in & tt[2];
        x[6] = r_in & tt[1];
        x[7] = (~r_in & tt[1]) | (~d[7] & i_bit & tt[3]) | ((d[0] | d[1] | d[2] | d[6]) & tt[4]);
        // priority encode: the highest-index active source owns the bus
        s_d   = x[7] ? 3'd7 : x[6] ? 3'd6 : x[5] ? 3'd5 : x[4] ? 3'd4 :
                x[3] ? 3'd3 : x[2] ? 3'd2 : x[1] ? 3'd1 : 3'd0;
        err_d = $countones(x) > 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 3'd0;
            err_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            err_q <= err_d;
        end
    end

    assign bus.s       = s_q;
    assign bus.bus_err = err_q;
endmodule

// File: tb/tb_common_bus_select.sv
// tb_common_bus_select: directed-vector bench for common_bus_select with immediate assertions.
module tb_common_bus_select;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    common_bus_select_if bus ();

    common_bus_select dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got_s, input logic [2:0] exp_s,
                         input logic got_e);
        total++;
        assert (got_s === exp_s) else begin
            bad++;
            $error("FAIL %s: s observed=%b expected=%b", tag, got_s, exp_s);
        end
        total++;
        assert (got_e === 1'b0) else begin
            bad++;
            $error("FAIL %s: bus_err observed=%b expected=0", tag, got_e);
        end
    endtask

    task automatic step(input string tag, input logic [15:0] ir, input logic [2:0] tv,
                        input logic [2:0] exp_s);
        bus.in_ir = ir;
        bus.t     = tv;
        @(posedge clk);
        #1;
        check(tag, bus.s, exp_s, bus.bus_err);
    endtask

    initial begin
        logic [2:0] lat_exp [8];
        lat_exp = '{3'b010, 3'b111, 3'b101, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000};
        bus.in_ir = 16'h0000;
        bus.t     = 3'd1;
`ifdef INTERRUPT_CYCLE_EN
        bus.r     = 1'b0;
`endif
        #2;
        check("reset_initial", bus.s, 3'b000, bus.bus_err);
        @(negedge clk);
        rst_n = 1'b1;
        step("pre_reset_t1", 16'h0000, 3'd1, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", bus.s, 3'b000, bus.bus_err);
        @(posedge clk);
        #1;
        check("reset_held_edge", bus.s, 3'b000, bus.bus_err);
        @(negedge clk);
        rst_n = 1'b1;

        step("fetch_t0", 16'h0000, 3'd0, 3'b010);
        step("fetch_t1", 16'h0000, 3'd1, 3'b111);
        step("fetch_t2", 16'h0000, 3'd2, 3'b101);
        step("fetch_t3", 16'h0000, 3'd3, 3'b000);

        step("bun_t4", 16'h4000, 3'd4, 3'b001);
        step("bsa_t4", 16'h5000, 3'd4, 3'b010);
        step("bsa_t5", 16'h5000, 3'd5, 3'b001);
        step("sta_t4", 16'h3000, 3'd4, 3'b100);
        step("isz_t4", 16'h6000, 3'd4, 3'b111);
        step("isz_t6", 16'h6000, 3'd6, 3'b011);
        step("and_t4", 16'h0000, 3'd4, 3'b111);
        step("lda_t5", 16'h2000, 3'd5, 3'b000);

        step("indirect_t3", 16'h8000, 3'd3, 3'b111);
        step("d7_i_t3", 16'hF000, 3'd3, 3'b000);
        step("d7_noi_t3", 16'h7FFF, 3'd3, 3'b000);
        step("addr_ignored_t1", 16'h0ABC, 3'd1, 3'b111);
        step("addr_ignored_t3", 16'h8ABC, 3'd3, 3'b111);
        step("t7_idle", 16'h6FFF, 3'd7, 3'b000);

        step("lat_prime", 16'h2000, 3'd7, 3'b000);
        for (int k = 0; k < 8; k++) begin
            bus.in_ir = 16'h2000;
            bus.t     = k[2:0];
            #2;
            check($sformatf("lat_hold_%0d", k), bus.s,
                  (k == 0) ? 3'b000 : lat_exp[k-1], bus.bus_err);
            @(posedge clk);
            #1;
            check($sformatf("lat_t%0d", k), bus.s, lat_exp[k], bus.bus_err);
        end

`ifdef INTERRUPT_CYCLE_EN
        bus.r = 1'b1;
        step("int_t0", 16'h0000, 3'd0, 3'b010);
        step("int_t1", 16'h0000, 3'd1, 3'b110);
        step("int_t2", 16'h0000, 3'd2, 3'b000);
        step("int_isz_t4", 16'h6000, 3'd4, 3'b111);
        bus.r = 1'b0;
        step("noint_t1", 16'h0000, 3'd1, 3'b111);
        step("noint_t2", 16'h0000, 3'd2, 3'b101);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
